interrupt_arbiter: RTL
======================

# interrupt_arbiter

Sequential external-interrupt arbiter between the platform IRQ lines and the CPU trap logic. Synchronises and edge-detects up to EXT_IRQ_COUNT asynchronous request lines, latches them as pending and masks them with the CSR enables. It selects one winner, presents it to the core as `interrupt` plus `intCode`, and sequences the take/return handshake so only one external interrupt is in service at a time.

## Interface
- `EXT_IRQ_COUNT`, default 4: number of external request lines, legal range 1..16.
- `clk`  input  1  system clock; all state updates on its rising edge.
- `reset`  input  1  asynchronous, active-high; clears all state immediately.
- `irqBus`  input  EXT_IRQ_COUNT  raw asynchronous request lines, rising-edge sensitive.
- `irqEnable`  input  EXT_IRQ_COUNT  per-line enable mask from the CSR file.
- `globalEnable`  input  1  global interrupt enable (mstatus.MIE).
- `intAck`  input  1  one-cycle pulse from the core: trap for the presented interrupt taken.
- `intDone`  input  1  one-cycle pulse from the core: `mret` executed, handler finished.
- `interrupt`  output  1  registered interrupt request to the core.
- `intCode`  output  31  registered cause code of the presented interrupt.
- `inService`  output  1  high while a taken interrupt has not yet returned.
- `pending`  output  EXT_IRQ_COUNT  current pending register, readable via CSR.

## Operation
- Input path:
  - Each `irqBus` bit passes through a 2-flop synchroniser (`s1`, `s2`), then a delay flop `s3`.
  - Edge = `s2 & ~s3`.
  - An edge sets the corresponding `pending` bit. Levels never re-set it.
- Candidates: `pending & irqEnable`. Winner selection:
  - Default: the lowest index wins.
  - With the round-robin option, see Configuration.
- `intCode` = 16 + winner index, zero-extended to 31 bits. This is the platform-custom cause range.
- FSM states:
  - IDLE: if `globalEnable` and candidates ≠ 0, latch the winner index and `intCode`, set `interrupt`=1, go to REQUEST.
  - REQUEST:
    - `interrupt` and `intCode` are held stable.
    - On `intAck`: clear the winner's pending bit, set `interrupt`=0 and `inService`=1, go to SERVICE.
    - If `globalEnable` drops, or the winner's `irqEnable` bit drops, before `intAck`: set `interrupt`=0, go to IDLE. The pending bit is retained.
  - SERVICE: on `intDone`, set `inService`=0 and go to IDLE. New edges still set pending bits, but nothing is presented.
- Ignored inputs: `intAck` outside REQUEST; `intDone` outside SERVICE.
- Simultaneous clear (from `intAck`) and new edge on the same bit in the same cycle: set wins, and the bit stays pending.
- `intCode` holds its last value after `interrupt` falls. It changes only when a new winner is latched.

## Timing
- Reset values:
  - `interrupt`=0, `intCode`=0, `inService`=0, `pending`=0.
  - All synchroniser and delay flops 0; FSM=IDLE; round-robin pointer = EXT_IRQ_COUNT-1.
- Latency, with `irqBus` rising before clock edge E0:
  - `s1` at E0, `s2` at E1, `pending` bit at E2.
  - `interrupt`/`intCode` valid after E3, provided IDLE and enabled.
  - Total: 4 edges from pin to request.
- `intAck` sampled at edge E: `interrupt`=0 and `inService`=1 after E. Pending bit cleared at E.
- `intDone` sampled at edge E: IDLE after E. Earliest re-presentation after E+1, i.e. minimum one idle cycle between services.
- Reset asserted mid-operation (any state): outputs return to reset values asynchronously. Pending requests are lost.

## Configuration
- `IRQ_ARB_ROUND_ROBIN_EN` defined:
  - A pointer register holds the last winner index.
  - The search starts at pointer+1 and wraps modulo EXT_IRQ_COUNT.
  - The pointer updates on `intAck` only.
- `IRQ_ARB_ROUND_ROBIN_EN` not defined: fixed priority, lowest index highest. No pointer register is instantiated.

## Test plan
- Reset, then raise `irqBus`[2] with enables set:
  - `pending`=0100 after 3 edges.
  - `interrupt`=1, `intCode`=18 after the 4th edge.
  - `intAck` pulse → `interrupt`=0, `inService`=1, `pending`=0000.
- Lines 1 and 3 rise together, fixed priority:
  - First grant `intCode`=17.
  - After `intAck` and `intDone`, next grant `intCode`=19.
  - With the round-robin macro and pointer=1: grant 19 first, then 17.
- Hold `irqBus`[0] high for 20 cycles: exactly one pending set and one presentation. No re-trigger after `intDone`.
- In REQUEST, drop `globalEnable`: `interrupt`=0 next edge, `pending` bit kept. Restore it: re-presented with the same `intCode`.
- New edge on the winner's line in the same cycle as `intAck`: the bit remains pending and is re-presented after `intDone`.
- Assert `reset` in SERVICE with `pending`=1010: all outputs 0 immediately. `intAck`/`intDone` pulses with no request cause no state change.

Source files
------------

// File: rtl/interrupt_arbiter.sv
// External-interrupt arbiter: synchronise, edge-detect, latch pending, select one winner, run the
// take/return handshake. Define IRQ_ARB_ROUND_ROBIN_EN for round-robin selection (else fixed priority).
module interrupt_arbiter #(
    parameter int unsigned EXT_IRQ_COUNT = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [EXT_IRQ_COUNT-1:0] irqBus,
    input  logic [EXT_IRQ_COUNT-1:0] irqEnable,
    input  logic                     globalEnable,
    input  logic                     intAck,
    input  logic                     intDone,
    output logic                     interrupt,
    output logic [30:0]              intCode,
    output logic                     inService,
    output logic [EXT_IRQ_COUNT-1:0] pending
);

    localparam int unsigned IDX_W = (EXT_IRQ_COUNT > 1) ? $clog2(EXT_IRQ_COUNT) : 1;

    localparam logic [1:0] StIdle    = 2'd0;
    localparam logic [1:0] StRequest = 2'd1;
    localparam logic [1:0] StService = 2'd2;

    logic [EXT_IRQ_COUNT-1:0] s1, s2, s3, rise, cand, clr;
    logic [EXT_IRQ_COUNT-1:0] pending_q, pending_d;
    logic [1:0]               state_q, state_d;
    logic [IDX_W-1:0]         win_idx, win_q, win_d;
    logic                     win_found;
    logic                     irq_q, irq_d, svc_q, svc_d;
    logic [30:0]              code_q, code_d;

    assign rise = s2 & ~s3;
    assign cand = pending_q & irqEnable;

`ifdef IRQ_ARB_ROUND_ROBIN_EN
    logic [IDX_W-1:0] rr_ptr_q;

    // Search starts one past the last acknowledged winner and wraps.
    always_comb begin
        int j;
        j         = 0;
        win_found = 1'b0;
        win_idx   = '0;
        for (int k = 1; k <= int'(EXT_IRQ_COUNT); k++) begin
            j = (int'(rr_ptr_q) + k) % int'(EXT_IRQ_COUNT);
            if (!win_found && cand[j]) begin
                win_found = 1'b1;
                win_idx   = IDX_W'(j);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr_q <= IDX_W'(EXT_IRQ_COUNT - 1);
        end else if (state_q == StRequest && intAck) begin
            rr_ptr_q <= win_q;
        end
    end
`else
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int i = 0; i < int'(EXT_IRQ_COUNT); i++) begin
            if (!win_found && cand[i]) begin
                win_found = 1'b1;
                win_idx   = IDX_W'(i);
            end
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        irq_d   = irq_q;
        svc_d   = svc_q;
        code_d  = code_q;
        win_d   = win_q;
        clr     = '0;
        case (state_q)
            StIdle: begin
                if (globalEnable && win_found) begin
                    win_d   = win_idx;
                    code_d  = 31'd16 + 31'(win_idx);
                    irq_d   = 1'b1;
                    state_d = StRequest;
                end
            end
            StRequest: begin
                if (intAck) begin
                    clr[win_q] = 1'b1;
                    irq_d      = 1'b0;
                    svc_d      = 1'b1;
                    state_d    = StService;
                end else if (!globalEnable || !irqEnable[win_q]) begin
                    irq_d   = 1'b0;
                    state_d = StIdle;
                end
            end
            StService: begin
                if (intDone) begin
                    svc_d   = 1'b0;
                    state_d = StIdle;
                end
            end
            default: begin
                irq_d   = 1'b0;
                svc_d   = 1'b0;
                state_d = StIdle;
            end
        endcase
    end

    // A new edge outranks the acknowledge clear on the same bit.
    assign pending_d = (pending_q & ~clr) | rise;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1        <= '0;
            s2        <= '0;
            s3        <= '0;
            pending_q <= '0;
            state_q   <= StIdle;
            win_q     <= '0;
            irq_q     <= 1'b0;
            svc_q     <= 1'b0;
            code_q    <= '0;
        end else begin
            s1        <= irqBus;
            s2        <= s1;
            s3        <= s2;
            pending_q <= pending_d;
            state_q   <= state_d;
            win_q     <= win_d;
            irq_q     <= irq_d;
            svc_q     <= svc_d;
            code_q    <= code_d;
        end
    end

    assign interrupt = irq_q;
    assign intCode   = code_q;
    assign inService = svc_q;
    assign pending   = pending_q;

endmodule
